// File: rtl/adc_scan_sequencer_pkg.sv
// Shared types and default sizing for the ADC scan sequencer.
package adc_seq_pkg;

  localparam int NCHAN = 8;
  localparam int CHW   = $clog2(NCHAN);
  localparam int DW    = 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_DISCARD = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/scan_next_chan.sv
// Finds the first set bit of a channel mask strictly after the current channel, wrapping around.
module scan_next_chan
  import adc_seq_pkg::*;
#(
  parameter int NCHAN = adc_seq_pkg::NCHAN,
  parameter int CW    = $clog2(NCHAN)
) (
  input  logic [NCHAN-1:0] mask,
  input  logic [CW-1:0]    cur,
  output logic [CW-1:0]    next_chan,
  output logic             any_set
);

  assign any_set = |mask;

  // Search from the farthest offset down so the nearest set bit wins; offset NCHAN is cur itself.
  always_comb begin
    next_chan = cur;
    for (int k = NCHAN; k >= 1; k--) begin
      next_chan = mask[cur + CW'(k)] ? (cur + CW'(k)) : next_chan;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Chooses the ADC channel (manual or round-robin scan), drops settling conversions
// and keeps the latest valid result per channel for the display mux.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NCHAN  = adc_seq_pkg::NCHAN,
  parameter int DW     = adc_seq_pkg::DW,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [$clog2(NCHAN)-1:0] sel_chan,
  input  logic [NCHAN-1:0]         scan_mask,
  input  logic                     conv_done,
  input  logic [DW-1:0]            adc_result,
  output logic [$clog2(NCHAN)-1:0] chan,
  input  logic [$clog2(NCHAN)-1:0] rd_chan,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_valid,
  output logic                     upd_stb,
  output logic [$clog2(NCHAN)-1:0] upd_chan
);

  localparam int         CW         = $clog2(NCHAN);
  localparam logic [1:0] SETTLE_CNT = 2'(SETTLE);

  state_t           state_r;
  logic [1:0]       cnt_r;
  logic [CW-1:0]    chan_r;
  logic [CW-1:0]    upd_chan_r;
  logic             upd_stb_r;
  logic [DW-1:0]    store_r [NCHAN];
  logic [NCHAN-1:0] valid_r;

  logic [CW-1:0]    scan_chan_s;
  logic             any_set_s;
  logic [CW-1:0]    target_s;
  logic             hold_s;

  scan_next_chan #(.NCHAN(NCHAN), .CW(CW)) u_next (
    .mask      (scan_mask),
    .cur       (chan_r),
    .next_chan (scan_chan_s),
    .any_set   (any_set_s)
  );

  // Target channel for the next SELECT; an empty scan mask parks the sequencer.
  always_comb begin
    target_s = chan_r;
    hold_s   = 1'b0;
    if (mode) begin
      target_s = scan_chan_s;
      hold_s   = ~any_set_s;
    end else begin
      target_s = sel_chan;
    end
  end

  // Sequencer state machine, result store and update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 2'd0;
      chan_r     <= {CW{1'b0}};
      upd_chan_r <= {CW{1'b0}};
      upd_stb_r  <= 1'b0;
      valid_r    <= {NCHAN{1'b0}};
      for (int i = 0; i < NCHAN; i++) begin
        store_r[i] <= {DW{1'b0}};
      end
    end else begin
      upd_stb_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          state_r <= S_SELECT;
        end
        S_SELECT: begin
          if (!hold_s) begin
            if (target_s != chan_r) begin
              chan_r  <= target_s;
              cnt_r   <= SETTLE_CNT;
              state_r <= S_DISCARD;
            end else begin
              state_r <= S_CAPTURE;
            end
          end
        end
        S_DISCARD: begin
          // The ADC result lags the channel config, so these strobes still carry the old channel.
          if (conv_done) begin
            cnt_r <= cnt_r - 2'd1;
            if (cnt_r == 2'd1) begin
              state_r <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (conv_done) begin
            store_r[chan_r] <= adc_result;
            valid_r[chan_r] <= 1'b1;
            upd_stb_r       <= 1'b1;
            upd_chan_r      <= chan_r;
            state_r         <= S_SELECT;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign chan     = chan_r;
  assign upd_stb  = upd_stb_r;
  assign upd_chan = upd_chan_r;
  assign rd_data  = store_r[rd_chan];
  assign rd_valid = valid_r[rd_chan];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_adc_scan_sequencer;

  localparam int NCHAN  = 8;
  localparam int CW     = 3;
  localparam int DW     = 12;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             mode;
  logic [CW-1:0]    sel_chan;
  logic [NCHAN-1:0] scan_mask;
  logic             conv_done;
  logic [DW-1:0]    adc_result;
  logic [CW-1:0]    chan;
  logic [CW-1:0]    rd_chan;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             upd_stb;
  logic [CW-1:0]    upd_chan;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.NCHAN(NCHAN), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .sel_chan   (sel_chan),
    .scan_mask  (scan_mask),
    .conv_done  (conv_done),
    .adc_result (adc_result),
    .chan       (chan),
    .rd_chan    (rd_chan),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .upd_stb    (upd_stb),
    .upd_chan   (upd_chan)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: m_left counts strobes still to be consumed (discards plus the captured one);
  // zero means a channel decision is due on the next clock.
  int  m_chan;
  int  m_left;
  bit  m_boot;
  bit  m_upd_stb;
  int  m_upd_chan;
  int  m_store [NCHAN];
  bit  m_valid [NCHAN];
  bit  m_live = 1'b0;
  int  m_t;

  function automatic int scan_target(input int cur, input logic [NCHAN-1:0] m);
    for (int k = 1; k <= NCHAN; k++) begin
      if (m[(cur + k) % NCHAN]) return (cur + k) % NCHAN;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_chan = 0; m_left = 0; m_boot = 1'b1; m_upd_stb = 1'b0; m_upd_chan = 0;
      for (int i = 0; i < NCHAN; i++) begin
        m_store[i] = 0;
        m_valid[i] = 1'b0;
      end
      m_live = 1'b1;
    end else begin
      m_upd_stb = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_left == 0) begin
        m_t = mode ? scan_target(m_chan, scan_mask) : int'(sel_chan);
        if (m_t >= 0) begin
          if (m_t != m_chan) begin
            m_chan = m_t;
            m_left = SETTLE + 1;
          end else begin
            m_left = 1;
          end
        end
      end else if (conv_done) begin
        m_left--;
        if (m_left == 0) begin
          m_store[m_chan] = int'(adc_result);
          m_valid[m_chan] = 1'b1;
          m_upd_stb = 1'b1;
          m_upd_chan = m_chan;
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("chan",     32'(chan),     32'(m_chan));
      check("upd_stb",  32'(upd_stb),  32'(m_upd_stb));
      check("upd_chan", 32'(upd_chan), 32'(m_upd_chan));
      check("rd_data",  32'(rd_data),  32'(m_store[rd_chan]));
      check("rd_valid", 32'(rd_valid), 32'(m_valid[rd_chan]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [DW-1:0] v);
    conv_done  = 1'b1;
    adc_result = v;
    cyc(1);
    conv_done  = 1'b0;
    adc_result = DW'($urandom);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  int exp_seq [3] = '{2, 7, 0};
  int gap;
  logic [DW-1:0] v;

  initial begin
    reset = 1'b1; mode = 1'b0; sel_chan = 3'd0; scan_mask = 8'd0;
    conv_done = 1'b0; adc_result = 12'd0; rd_chan = 3'd0;
    cyc(2);
    check("t1_reset_chan", 32'(chan), 32'd0);
    check("t1_reset_stb", 32'(upd_stb), 32'd0);

    // 1: manual channel 0, first strobe lands in SELECT and is dropped
    reset = 1'b0;
    cyc(1);
    pulse(12'h123); cyc(3);
    check("t1_drop_valid", 32'(rd_valid), 32'd0);
    pulse(12'h123);
    check("t1_stb", 32'(upd_stb), 32'd1);
    check("t1_upd_chan", 32'(upd_chan), 32'd0);
    check("t1_data", 32'(rd_data), 32'h123);
    cyc(3); pulse(12'h123); cyc(3);
    check("t1_chan", 32'(chan), 32'd0);

    // 2: manual switch to channel 5, one discarded conversion
    do_reset; sel_chan = 3'd5; rd_chan = 3'd5;
    cyc(2);
    pulse(12'hAAA); cyc(3);
    check("t2_discard_valid", 32'(rd_valid), 32'd0);
    pulse(12'h5B7);
    check("t2_valid", 32'(rd_valid), 32'd1);
    check("t2_data", 32'(rd_data), 32'h5B7);
    check("t2_chan", 32'(chan), 32'd5);
    cyc(3);

    // 3: scan over mask 1000_0101 from channel 0
    do_reset; mode = 1'b1; scan_mask = 8'b1000_0101;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      rd_chan = 3'(exp_seq[i]);
      v = DW'($urandom);
      pulse(12'hAAA); cyc(3);
      pulse(v);
      check("t3_stb", 32'(upd_stb), 32'd1);
      check("t3_upd_chan", 32'(upd_chan), 32'(exp_seq[i]));
      check("t3_data", 32'(rd_data), 32'(v));
      cyc(3);
    end
    check("t3_wrap_chan", 32'(chan), 32'd2);

    // 4: empty scan mask parks the sequencer
    do_reset; scan_mask = 8'd0;
    cyc(2);
    repeat (5) begin
      pulse(DW'($urandom));
      check("t4_no_stb", 32'(upd_stb), 32'd0);
      cyc(3);
    end
    check("t4_chan", 32'(chan), 32'd0);
    for (int i = 0; i < NCHAN; i++) begin
      rd_chan = 3'(i); cyc(1);
      check("t4_valid", 32'(rd_valid), 32'd0);
    end

    // 5: reset while discarding after store[3] was written
    do_reset; mode = 1'b0; sel_chan = 3'd3; rd_chan = 3'd3;
    cyc(2);
    pulse(12'hAAA); cyc(3);
    pulse(12'h0FF);
    check("t5_data", 32'(rd_data), 32'h0FF);
    sel_chan = 3'd6;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("t5_chan", 32'(chan), 32'd0);
    check("t5_stb", 32'(upd_stb), 32'd0);
    for (int i = 0; i < NCHAN; i++) begin
      rd_chan = 3'(i); cyc(1);
      check("t5_valid", 32'(rd_valid), 32'd0);
      check("t5_data0", 32'(rd_data), 32'd0);
    end

    // 6: select wiggles during DISCARD are ignored
    do_reset; sel_chan = 3'd1; rd_chan = 3'd1;
    cyc(2);
    sel_chan = 3'd2; cyc(1);
    check("t6_hold_chan", 32'(chan), 32'd1);
    sel_chan = 3'd1; cyc(1);
    pulse(12'hAAA); cyc(3);
    pulse(12'h321);
    check("t6_upd_chan", 32'(upd_chan), 32'd1);
    check("t6_data", 32'(rd_data), 32'h321);
    cyc(3);
    pulse(12'h456);
    check("t6_no_rediscard", 32'(rd_data), 32'h456);
    cyc(3);

    // Randomized traffic with mode/mask/select changes and occasional resets
    gap = 0;
    for (int n = 0; n < 5000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) sel_chan = 3'($urandom);
      if ($urandom_range(0, 39) == 0) scan_mask = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      rd_chan = 3'($urandom);
      if (gap == 0 && $urandom_range(0, 2) == 0) begin
        conv_done  = 1'b1;
        adc_result = DW'($urandom);
        gap = $urandom_range(2, 5);
      end else begin
        conv_done = 1'b0;
        if (gap > 0) gap--;
      end
      cyc(1);
    end
    conv_done = 1'b0;
    reset = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
